// File: rtl/code_loader.sv
// Program loader: assembles 16-bit words from a byte stream, writes them
// into code memory, then holds the processor in run until stopped.
module code_loader #(
    parameter int ADDR_W    = 9,
    parameter int WORD_W    = 16,
    parameter int MAX_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr_in,
    output logic [WORD_W-1:0] code_in,
    output logic              run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, RUN, ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [15:0]         count_q;
    logic [7:0]          hi_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   code_addr_q;
    logic [WORD_W-1:0]   code_in_q;
    logic [ADDR_W:0]     wl_q;
    logic                err_q;

    logic                xfer;
    logic                launch;
    logic                hdr_bad;
    logic [15:0]         hdr_count;
    logic [ADDR_W:0]     wl_next;

    assign rx_ready  = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                       (state_q == DATA_HI) || (state_q == DATA_LO);
    assign busy      = rx_ready || (state_q == WRITE);
    assign code_w_en = (state_q == WRITE);
    assign run       = (state_q == RUN);
    assign err       = err_q;
    assign code_addr_in = code_addr_q;
    assign code_in      = code_in_q;
    assign words_loaded = wl_q;

    assign xfer      = rx_valid && rx_ready;
    assign launch    = ((state_q == IDLE) || (state_q == ERROR)) &&
                       start && !stop;
    assign hdr_count = {count_q[15:8], rx_data};
    assign hdr_bad   = (hdr_count == 16'd0) || ({1'b0, hdr_count} > MAX_W);
    assign wl_next   = wl_q + 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ERROR: if (launch) state_d = HDR_HI;
            HDR_HI: begin
                if (stop) state_d = IDLE;
                else if (xfer) state_d = HDR_LO;
            end
            HDR_LO: begin
                if (stop) state_d = IDLE;
                else if (xfer) state_d = hdr_bad ? ERROR : DATA_HI;
            end
            DATA_HI: begin
                if (stop) state_d = IDLE;
                else if (xfer) state_d = DATA_LO;
            end
            DATA_LO: begin
                if (stop) state_d = IDLE;
                else if (xfer) state_d = WRITE;
            end
            WRITE: begin
                if (stop) state_d = IDLE;
                else if (16'(wl_next) == count_q) state_d = RUN;
                else state_d = DATA_HI;
            end
            RUN: if (stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output address/data are captured when the word completes so they stay
    // stable through WRITE and hold afterwards while addr_q moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            hi_q        <= '0;
            addr_q      <= '0;
            code_addr_q <= '0;
            code_in_q   <= '0;
            wl_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            if (launch) begin
                wl_q   <= '0;
                addr_q <= '0;
                err_q  <= 1'b0;
            end
            if (xfer && !stop) begin
                unique case (state_q)
                    HDR_HI: count_q[15:8] <= rx_data;
                    HDR_LO: begin
                        count_q[7:0] <= rx_data;
                        if (hdr_bad) err_q <= 1'b1;
                    end
                    DATA_HI: hi_q <= rx_data;
                    DATA_LO: begin
                        code_addr_q <= addr_q;
                        code_in_q   <= WORD_W'({hi_q, rx_data});
                    end
                    default: ;
                endcase
            end
            if (state_q == WRITE) begin
                addr_q <= addr_q + 1'b1;
                wl_q   <= wl_next;
            end
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: randomized programs and stalls
// compared against a byte-stream-level reference model.
module tb_code_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        code_w_en;
    logic [8:0]  code_addr_in;
    logic [15:0] code_in;
    logic        run;
    logic        busy;
    logic        err;
    logic [9:0]  words_loaded;

    int checks = 0;
    int failures = 0;
    int inv_bad = 0;

    logic [8:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    logic [8:0]  exp_addr[$];
    logic [15:0] exp_data[$];

    code_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .code_w_en(code_w_en), .code_addr_in(code_addr_in),
        .code_in(code_in), .run(run), .busy(busy), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && code_w_en) begin
            wr_addr.push_back(code_addr_in);
            wr_data.push_back(code_in);
        end
        if (code_w_en && run) inv_bad++;
    end

    function automatic bq_t make_prog(input int n);
        bq_t q;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        repeat (2 * n) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: header gives word count; accepted range 1..512.
    function automatic bit build_expect(input bq_t b);
        int cnt;
        exp_addr.delete();
        exp_data.delete();
        cnt = {b[0], b[1]};
        if (cnt == 0 || cnt > 512) return 1'b0;
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back(9'(i));
            exp_data.push_back({b[2 + 2 * i], b[3 + 2 * i]});
        end
        return 1'b1;
    endfunction

    task automatic run_load(input bq_t b, input int stall_pct,
                            input int stall_at, input int abort_after,
                            output int edges, output bit tout);
        int idx;
        int left;
        bit pend;
        bit stopping;
        idx = 0;
        left = 4;
        pend = 1'b0;
        stopping = 1'b0;
        edges = -1;
        tout = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
        start = 1'b1;
        stop = 1'b0;
        rx_valid = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (pend) idx++;
            pend = 1'b0;
            if (stopping) begin
                stop = 1'b0;
                tout = 1'b0;
                break;
            end
            if (run || err) begin
                rx_valid = 1'b0;
                tout = 1'b0;
                break;
            end
            if (abort_after >= 0 && idx == abort_after) begin
                stop = 1'b1;
                rx_valid = 1'b0;
                stopping = 1'b1;
            end else if (idx == stall_at && left > 0) begin
                rx_valid = 1'b0;
                left--;
            end else if (idx < b.size() &&
                         $urandom_range(99) >= stall_pct) begin
                rx_valid = 1'b1;
                rx_data = b[idx];
            end else begin
                rx_valid = 1'b0;
            end
            pend = rx_valid && rx_ready;
        end
        rx_valid = 1'b0;
    endtask

    task automatic halt();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, code_w_en, run, busy, err} !== 5'b0 ||
            code_addr_in !== 9'd0 || code_in !== 16'd0 ||
            words_loaded !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b we=%b run=%b busy=%b err=%b addr=%h data=%h wl=%0d want all 0",
                     rx_ready, code_w_en, run, busy, err,
                     code_addr_in, code_in, words_loaded);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || run !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b run=%b want 0 0",
                     busy, run);
        end
    endtask

    task automatic test_single_word();
        bq_t p;
        int edges;
        bit tout;
        int nbad;
        p = '{8'h00, 8'h01, 8'hAB, 8'hCD};
        void'(build_expect(p));
        run_load(p, 0, -1, -1, edges, tout);
        checks++;
        if (tout || edges !== 5) begin
            failures++;
            $display("FAIL single_latency: got %0d edges (timeout=%0b) want 5",
                     edges, tout);
        end
        nbad = 0;
        if (wr_addr.size() != 1) nbad++;
        else if (wr_addr[0] !== 9'd0 || wr_data[0] !== 16'hABCD) nbad++;
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL single_write: got %0d writes first=%h/%h want 1 write 000/abcd",
                     wr_addr.size(), wr_addr.size() ? wr_addr[0] : 9'h0,
                     wr_data.size() ? wr_data[0] : 16'h0);
        end
        checks++;
        if (words_loaded !== 10'd1 || run !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_state: got wl=%0d run=%b busy=%b want 1 1 0",
                     words_loaded, run, busy);
        end
    endtask

    task automatic test_stall();
        bq_t p;
        int edges;
        bit tout;
        int nbad;
        halt();
        p = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        void'(build_expect(p));
        run_load(p, 0, 3, -1, edges, tout);
        nbad = 0;
        if (wr_addr.size() != exp_addr.size()) nbad++;
        else foreach (exp_addr[i])
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i])
                nbad++;
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL stall_writes: got %0d writes (%0d bad) want %0d",
                     wr_addr.size(), nbad, exp_addr.size());
        end
        checks++;
        if (tout || run !== 1'b1 || edges !== 15) begin
            failures++;
            $display("FAIL stall_run: got run=%b edges=%0d timeout=%0b want 1 15 0",
                     run, edges, tout);
        end
    endtask

    task automatic test_bad_header();
        bq_t p;
        int edges;
        bit tout;
        int nbad;
        halt();
        p = '{8'h00, 8'h00};
        void'(build_expect(p));
        run_load(p, 0, -1, -1, edges, tout);
        checks++;
        if (tout || err !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 ||
            wr_addr.size() != 0) begin
            failures++;
            $display("FAIL bad_zero: got err=%b busy=%b rdy=%b writes=%0d want 1 0 0 0",
                     err, busy, rx_ready, wr_addr.size());
        end
        p = '{8'h02, 8'h01};
        run_load(p, 0, -1, -1, edges, tout);
        checks++;
        if (tout || err !== 1'b1 || wr_addr.size() != 0 || run !== 1'b0) begin
            failures++;
            $display("FAIL bad_513: got err=%b writes=%0d run=%b want 1 0 0",
                     err, wr_addr.size(), run);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        p = make_prog(3);
        void'(build_expect(p));
        run_load(p, 20, -1, -1, edges, tout);
        nbad = 0;
        if (wr_addr.size() != exp_addr.size()) nbad++;
        else foreach (exp_addr[i])
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i])
                nbad++;
        checks++;
        if (tout || nbad != 0 || err !== 1'b0 || run !== 1'b1) begin
            failures++;
            $display("FAIL err_recover: got err=%b run=%b writes=%0d bad=%0d want 0 1 %0d 0",
                     err, run, wr_addr.size(), nbad, exp_addr.size());
        end
    endtask

    task automatic test_abort();
        bq_t p;
        int edges;
        bit tout;
        halt();
        p = make_prog(4);
        void'(build_expect(p));
        run_load(p, 0, -1, 4, edges, tout);
        checks++;
        if (busy !== 1'b0 || run !== 1'b0 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b run=%b rdy=%b want 0 0 0",
                     busy, run, rx_ready);
        end
        rx_valid = 1'b1;
        repeat (10) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 9'd0 ||
            wr_data[0] !== exp_data[0]) begin
            failures++;
            $display("FAIL abort_writes: got %0d writes want 1 at addr 0 data %h",
                     wr_addr.size(), exp_data[0]);
        end
        checks++;
        if (words_loaded !== 10'd1 || run !== 1'b0) begin
            failures++;
            $display("FAIL abort_count: got wl=%0d run=%b want 1 0",
                     words_loaded, run);
        end
    endtask

    task automatic test_run_halt();
        bq_t p;
        int edges;
        bit tout;
        p = make_prog(2);
        run_load(p, 0, -1, -1, edges, tout);
        repeat (10) @(negedge clk);
        checks++;
        if (run !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL run_hold: got run=%b busy=%b want 1 0", run, busy);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (run !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL run_stop: got run=%b busy=%b want 0 0", run, busy);
        end
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b0 || run !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_idle: got busy=%b rdy=%b run=%b want 0 0 0",
                     busy, rx_ready, run);
        end
    endtask

    task automatic test_random();
        bq_t p;
        int edges;
        bit tout;
        int nbad;
        for (int t = 0; t < 6; t++) begin
            halt();
            p = make_prog(int'($urandom_range(20, 1)));
            void'(build_expect(p));
            run_load(p, 30, -1, -1, edges, tout);
            nbad = 0;
            if (wr_addr.size() != exp_addr.size()) nbad++;
            else foreach (exp_addr[i])
                if (wr_addr[i] !== exp_addr[i] ||
                    wr_data[i] !== exp_data[i]) nbad++;
            checks++;
            if (tout || nbad != 0 || run !== 1'b1 ||
                words_loaded !== 10'(exp_addr.size())) begin
                failures++;
                $display("FAIL random_%0d: got writes=%0d bad=%0d wl=%0d run=%b want %0d 0 %0d 1",
                         t, wr_addr.size(), nbad, words_loaded, run,
                         exp_addr.size(), exp_addr.size());
            end
        end
    endtask

    task automatic test_max_len();
        bq_t p;
        int edges;
        bit tout;
        int nbad;
        halt();
        p = make_prog(512);
        void'(build_expect(p));
        run_load(p, 0, -1, -1, edges, tout);
        nbad = 0;
        if (wr_addr.size() != exp_addr.size()) nbad++;
        else foreach (exp_addr[i])
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i])
                nbad++;
        checks++;
        if (tout || nbad != 0 || edges !== 1538 ||
            words_loaded !== 10'd512) begin
            failures++;
            $display("FAIL max_len: got writes=%0d bad=%0d edges=%0d wl=%0d want 512 0 1538 512",
                     wr_addr.size(), nbad, edges, words_loaded);
        end
    endtask

    task automatic test_async_reset();
        bq_t p;
        int edges;
        bit tout;
        p = make_prog(2);
        run_load(p, 0, -1, -1, edges, tout);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({run, code_w_en, busy, err} !== 4'b0 || words_loaded !== 10'd0) begin
            failures++;
            $display("FAIL rst_mid_run: got run=%b we=%b busy=%b err=%b wl=%0d want 0",
                     run, code_w_en, busy, err, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h00;
        @(negedge clk);
        rx_data = 8'h02;
        @(negedge clk);
        rx_data = 8'h12;
        @(negedge clk);
        rx_data = 8'h34;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (code_w_en !== 1'b1 || code_in !== 16'h1234) begin
            failures++;
            $display("FAIL pre_rst_write: got we=%b data=%h want 1 1234",
                     code_w_en, code_in);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({run, code_w_en, busy, err} !== 4'b0 || code_in !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid_write: got run=%b we=%b busy=%b err=%b data=%h want 0",
                     run, code_w_en, busy, err, code_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || run !== 1'b0 || code_w_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_release: got busy=%b run=%b we=%b want 0 0 0",
                     busy, run, code_w_en);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_bad_header();
        test_abort();
        test_run_halt();
        test_random();
        test_max_len();
        test_async_reset();
        checks++;
        if (inv_bad != 0) begin
            failures++;
            $display("FAIL we_run_overlap: got %0d cycles want 0", inv_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
